// File: rtl/mips_mem_arbiter_if.sv
// Signal bundle between the arbiter, the Harvard CPU's two memory ports and the single Avalon-style bus.
// The master side is the arbiter itself; the slave side is the CPU plus bus fabric around it.
interface mips_mem_arbiter_if;
  // CPU side
  logic        cpu_active;
  logic [31:0] cpu_instr_address;
  logic [31:0] cpu_instr_readdata;
  logic [31:0] cpu_data_address;
  logic        cpu_data_read;
  logic        cpu_data_write;
  logic [31:0] cpu_data_writedata;
  logic [31:0] cpu_data_readdata;
  logic        cpu_clk_enable;
  // Bus side
  logic [31:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_writedata;
  logic [3:0]  bus_byteenable;
  logic [31:0] bus_readdata;
  logic        bus_waitrequest;
  logic        bus_error;

  modport master (
    input  cpu_active,
    input  cpu_instr_address,
    output cpu_instr_readdata,
    input  cpu_data_address,
    input  cpu_data_read,
    input  cpu_data_write,
    input  cpu_data_writedata,
    output cpu_data_readdata,
    output cpu_clk_enable,
    output bus_address,
    output bus_read,
    output bus_write,
    output bus_writedata,
    output bus_byteenable,
    input  bus_readdata,
    input  bus_waitrequest,
    output bus_error
  );

  modport slave (
    output cpu_active,
    output cpu_instr_address,
    input  cpu_instr_readdata,
    output cpu_data_address,
    output cpu_data_read,
    output cpu_data_write,
    output cpu_data_writedata,
    input  cpu_data_readdata,
    input  cpu_clk_enable,
    input  bus_address,
    input  bus_read,
    input  bus_write,
    input  bus_writedata,
    input  bus_byteenable,
    output bus_readdata,
    output bus_waitrequest,
    input  bus_error
  );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Serialises the Harvard CPU's instruction fetch and data access onto one Avalon-style bus,
// then strobes the CPU's clk_enable for one cycle so it commits the instruction.
module mips_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic               clk,
  input logic               reset,
  mips_mem_arbiter_if.master io
);

  localparam int unsigned CW         = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic        TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    FETCH,
    DATA,
    EXEC,
    HALT
  } state_t;

  state_t        state_reg, state_next;
  logic [31:0]   instr_reg, instr_next;
  logic [31:0]   load_reg, load_next;
  logic          error_reg, error_next;
  logic [CW-1:0] wait_cnt_reg, wait_cnt_next;

  logic          req_read;
  logic          req_write;
  logic [31:0]   req_address;
  logic [31:0]   req_writedata;
  logic          commit;
  logic          data_write;
  logic          data_read;

  // Store takes priority when the CPU decodes both from a malformed word.
  assign data_write = io.cpu_data_write;
  assign data_read  = io.cpu_data_read & ~io.cpu_data_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= FETCH;
      instr_reg    <= '0;
      load_reg     <= '0;
      error_reg    <= 1'b0;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      instr_reg    <= instr_next;
      load_reg     <= load_next;
      error_reg    <= error_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    instr_next    = instr_reg;
    load_next     = load_reg;
    error_next    = error_reg;
    wait_cnt_next = wait_cnt_reg;
    req_read      = 1'b0;
    req_write     = 1'b0;
    req_address   = '0;
    req_writedata = '0;
    commit        = 1'b0;

    unique case (state_reg)
      FETCH: begin
        if (!io.cpu_active) begin
          state_next = HALT;
        end else begin
          req_read    = 1'b1;
          req_address = io.cpu_instr_address;
          if (!io.bus_waitrequest) begin
            instr_next = io.bus_readdata;
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (data_write) begin
          req_write     = 1'b1;
          req_address   = io.cpu_data_address;
          req_writedata = io.cpu_data_writedata;
          if (!io.bus_waitrequest) state_next = EXEC;
        end else if (data_read) begin
          req_read    = 1'b1;
          req_address = io.cpu_data_address;
          if (!io.bus_waitrequest) begin
            load_next  = io.bus_readdata;
            state_next = EXEC;
          end
        end else begin
          // No memory operand: this cycle doubles as the commit cycle.
          commit     = 1'b1;
          state_next = FETCH;
        end
      end
      EXEC: begin
        commit     = 1'b1;
        state_next = FETCH;
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = FETCH;
      end
    endcase

    if (req_read || req_write) begin
      if (!io.bus_waitrequest) begin
        wait_cnt_next = '0;
      end else if (TIMEOUT_EN) begin
        if (wait_cnt_reg == WAIT_LAST) begin
          error_next    = 1'b1;
          state_next    = HALT;
          wait_cnt_next = '0;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
    end

    // Requests and the commit strobe must drop in the very cycle reset is seen.
    if (reset) begin
      req_read      = 1'b0;
      req_write     = 1'b0;
      req_address   = '0;
      req_writedata = '0;
      commit        = 1'b0;
    end
  end

  assign io.bus_read           = req_read;
  assign io.bus_write          = req_write;
  assign io.bus_address        = req_address;
  assign io.bus_writedata      = req_writedata;
  assign io.bus_byteenable     = 4'hF;
  assign io.bus_error          = error_reg;
  assign io.cpu_clk_enable     = commit;
  assign io.cpu_instr_readdata = instr_reg;
  assign io.cpu_data_readdata  = load_reg;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench: a tiny CPU stand-in and a bus responder around the arbiter, with a
// scoreboard of expected bus transactions and commit cycles.
module tb_mips_mem_arbiter;

  localparam logic [31:0] RESET_PC  = 32'hBFC00000;
  localparam logic [31:0] STORE_VAL = 32'h12345678;
  localparam logic [31:0] I_ADDIU   = 32'h24020005;  // addiu $2,$0,5
  localparam logic [31:0] I_JR0     = 32'h00000008;  // jr $0
  localparam logic [31:0] I_LW      = 32'h8C020100;  // lw $2,0x100($0)
  localparam logic [31:0] I_SW      = 32'hAC021000;  // sw $2,0x1000($0)

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_mem_arbiter_if io();

  mips_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // CPU stand-in: decodes the latched instruction, commits on clk_enable.
  logic [31:0] pc = RESET_PC;
  logic [31:0] v0 = '0;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [15:0] imm;
  assign op    = io.cpu_instr_readdata[31:26];
  assign funct = io.cpu_instr_readdata[5:0];
  assign imm   = io.cpu_instr_readdata[15:0];

  assign io.cpu_active         = (pc != 32'h0);
  assign io.cpu_instr_address  = pc;
  assign io.cpu_data_read      = io.cpu_active && (op == 6'h23);
  assign io.cpu_data_write     = io.cpu_active && (op == 6'h2B);
  assign io.cpu_data_address   = {16'h0, imm};
  assign io.cpu_data_writedata = STORE_VAL;

  always @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      v0 <= '0;
    end else if (io.cpu_clk_enable) begin
      if (op == 6'h23)      v0 <= io.cpu_data_readdata;
      else if (op == 6'h09) v0 <= {{16{imm[15]}}, imm};
      if (op == 6'h00 && funct == 6'h08) pc <= 32'h0;
      else                               pc <= pc + 32'd4;
    end
  end

  // Bus responder: word memory plus programmable stalls at one address.
  logic [31:0] mem [0:2047];
  logic        stuck = 1'b0;
  logic [31:0] stall_addr = 32'hFFFFFFFF;
  int          stall_n = 0;
  int          req_cycles = 0;
  logic        req;

  assign req = io.bus_read | io.bus_write;
  assign io.bus_waitrequest = stuck || (req && (io.bus_address == stall_addr) && (req_cycles < stall_n));
  assign io.bus_readdata = mem[io.bus_address[12:2]];

  always @(posedge clk) begin
    if (reset || !req || !io.bus_waitrequest) req_cycles <= 0;
    else                                      req_cycles <= req_cycles + 1;
  end

  // Scoreboard.
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } tx_t;

  tx_t sb[$];
  int  exp_en[$];
  int  cyc = 0;

  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  logic        stall_seen = 1'b0;
  logic [31:0] s_addr, s_wdata;
  logic        s_rd, s_wr;

  always @(negedge clk) begin
    tx_t t;
    if (!reset) begin
      if (stall_seen && !io.bus_error) begin
        check("stable_addr", io.bus_address, s_addr);
        check("stable_read", 32'(io.bus_read), 32'(s_rd));
        check("stable_write", 32'(io.bus_write), 32'(s_wr));
        check("stable_wdata", io.bus_writedata, s_wdata);
      end
      if (req) check("rw_exclusive", 32'(io.bus_read & io.bus_write), 32'd0);
      if (req && !io.bus_waitrequest) begin
        $display("[TB] cycle %0d %s addr=%h data=%h", cyc + 1, io.bus_write ? "WR" : "RD",
                 io.bus_address, io.bus_write ? io.bus_writedata : io.bus_readdata);
        if (sb.size() == 0) begin
          check("sb_nonempty", 32'(sb.size()), 32'd1);
        end else begin
          t = sb.pop_front();
          check("sb_kind", 32'(io.bus_write), 32'(t.wr));
          check("sb_addr", io.bus_address, t.addr);
          if (t.wr) check("sb_wdata", io.bus_writedata, t.data);
        end
      end
      if (io.cpu_clk_enable) begin
        $display("[TB] cycle %0d commit pc=%h", cyc + 1, pc);
        if (exp_en.size() == 0) check("commit_unexpected", 32'(cyc + 1), 32'd0);
        else                    check("commit_cycle", 32'(cyc + 1), 32'(exp_en.pop_front()));
      end
      stall_seen <= req && io.bus_waitrequest;
      s_addr     <= io.bus_address;
      s_wdata    <= io.bus_writedata;
      s_rd       <= io.bus_read;
      s_wr       <= io.bus_write;
    end else begin
      stall_seen <= 1'b0;
    end
  end

  task automatic push_tx(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    tx_t t;
    t.wr = wr;
    t.addr = addr;
    t.data = data;
    sb.push_back(t);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run_until_idle(input int budget);
    int k = 0;
    while ((sb.size() != 0 || exp_en.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("pending_after_budget", 32'(sb.size() + exp_en.size()), 32'd0);
  endtask

  task automatic check_quiet(input int n);
    int busy = 0;
    repeat (n) begin
      @(negedge clk);
      if (io.bus_read || io.bus_write || io.cpu_clk_enable) busy++;
    end
    check("halt_quiet", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int i = 0; i < 2048; i++) mem[i] = '0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_bus_read", 32'(io.bus_read), 32'd0);
    check("rst_bus_write", 32'(io.bus_write), 32'd0);
    check("rst_bus_address", io.bus_address, 32'd0);
    check("rst_clk_enable", 32'(io.cpu_clk_enable), 32'd0);
    check("rst_instr", io.cpu_instr_readdata, 32'd0);
    check("rst_load", io.cpu_data_readdata, 32'd0);
    check("rst_bus_error", 32'(io.bus_error), 32'd0);
    check("rst_byteenable", 32'(io.bus_byteenable), 32'hF);

    // ADDIU then JR $0, zero wait states: two cycles per instruction, then halt.
    mem[0] = I_ADDIU;
    mem[1] = I_JR0;
    push_tx(1'b0, RESET_PC, I_ADDIU);
    push_tx(1'b0, RESET_PC + 32'd4, I_JR0);
    exp_en.push_back(2);
    exp_en.push_back(4);
    release_reset();
    run_until_idle(50);
    check_quiet(25);
    check("t1_v0", v0, 32'd5);
    check("t1_instr_latched", io.cpu_instr_readdata, I_JR0);
    check("t1_load_held", io.cpu_data_readdata, 32'd0);

    // LW with three stalled data cycles.
    apply_reset();
    mem[0] = I_LW;
    mem[1] = I_JR0;
    mem[64] = 32'hDEADBEEF;
    stall_addr = 32'h100;
    stall_n = 3;
    push_tx(1'b0, RESET_PC, I_LW);
    push_tx(1'b0, 32'h100, 32'hDEADBEEF);
    push_tx(1'b0, RESET_PC + 32'd4, I_JR0);
    exp_en.push_back(6);
    exp_en.push_back(8);
    release_reset();
    run_until_idle(60);
    check_quiet(20);
    check("t2_v0", v0, 32'hDEADBEEF);
    check("t2_load_latched", io.cpu_data_readdata, 32'hDEADBEEF);
    check("t2_no_error", 32'(io.bus_error), 32'd0);

    // SW with zero wait states.
    apply_reset();
    mem[0] = I_SW;
    stall_n = 0;
    push_tx(1'b0, RESET_PC, I_SW);
    push_tx(1'b1, 32'h1000, STORE_VAL);
    push_tx(1'b0, RESET_PC + 32'd4, I_JR0);
    exp_en.push_back(3);
    exp_en.push_back(5);
    release_reset();
    run_until_idle(60);
    check_quiet(20);
    check("t3_load_held", io.cpu_data_readdata, 32'd0);

    // Fetch stuck in waitrequest: timeout after the fourth stalled cycle.
    apply_reset();
    stuck = 1'b1;
    release_reset();
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      check($sformatf("t4_read_c%0d", n), 32'(io.bus_read), 32'd1);
      check($sformatf("t4_err_c%0d", n), 32'(io.bus_error), 32'd0);
    end
    @(negedge clk);
    check("t4_error_set", 32'(io.bus_error), 32'd1);
    check("t4_read_dropped", 32'(io.bus_read), 32'd0);
    check_quiet(20);
    check("t4_error_sticky", 32'(io.bus_error), 32'd1);
    apply_reset();
    stuck = 1'b0;
    @(negedge clk);
    check("t4_error_cleared", 32'(io.bus_error), 32'd0);

    // Reset while the store is stalled on the bus.
    stall_addr = 32'h1000;
    stall_n = 3;
    push_tx(1'b0, RESET_PC, I_SW);
    release_reset();
    k = 0;
    while (!(io.bus_write && io.bus_waitrequest) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("t5_write_stalled", 32'(io.bus_write && io.bus_waitrequest), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("t5_write_dropped", 32'(io.bus_write), 32'd0);
    check("t5_read_dropped", 32'(io.bus_read), 32'd0);
    check("t5_no_commit", 32'(io.cpu_clk_enable), 32'd0);
    stall_n = 0;
    push_tx(1'b0, RESET_PC, I_SW);
    push_tx(1'b1, 32'h1000, STORE_VAL);
    push_tx(1'b0, RESET_PC + 32'd4, I_JR0);
    exp_en.push_back(3);
    exp_en.push_back(5);
    release_reset();
    @(negedge clk);
    check("t5_restart_pc", io.bus_address, RESET_PC);
    run_until_idle(60);
    check_quiet(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
